// File: rtl/ispm_lsu_bridge_pkg.sv
// Shared types for the I-SPM LSU bridge: dcache-style request/response structs,
// bridge state encoding and the read error pattern returned on an aborted load.
package ispm_lsu_bridge_pkg;

   localparam int unsigned INDEX_W = 12;
   localparam int unsigned TAG_W   = 44;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned BE_W    = DATA_W / 8;

   localparam logic [DATA_W-1:0] ISPM_ERR_RDATA = 64'hCA11AB1E_BADCAB1E;

   typedef struct packed {
      logic [INDEX_W-1:0] address_index;
      logic [TAG_W-1:0]   address_tag;
      logic [DATA_W-1:0]  data_wdata;
      logic               data_req;
      logic               data_we;
      logic [BE_W-1:0]    data_be;
      logic [1:0]         data_size;
      logic               kill_req;
      logic               tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic               data_gnt;
      logic               data_rvalid;
      logic [DATA_W-1:0]  data_rdata;
   } dcache_req_o_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_TAG = 2'd1,
      ISSUE    = 2'd2
   } ispm_bridge_state_t;

   // Writes are posted and finish on the controller's grant; reads finish on rvalid.
   function automatic logic is_completion(input logic we, input dcache_req_o_t rsp);
      return we ? rsp.data_gnt : rsp.data_rvalid;
   endfunction

endpackage

// File: rtl/ispm_lsu_watchdog.sv
// ISSUE-phase watchdog for the LSU bridge; only built with ISPM_LSU_BRIDGE_TIMEOUT_EN.
// Counts held cycles without completion and flags expiry at LIMIT.
`ifdef ISPM_LSU_BRIDGE_TIMEOUT_EN
module ispm_lsu_watchdog #(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expire_o = (cnt_q == CNT_W'(LIMIT));

   // Freeze at the limit so the count can never wrap back below it.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/ispm_lsu_bridge.sv
// LSU-to-I-SPM bridge: turns the split index/tag dcache protocol into one held request.
// Define ISPM_LSU_BRIDGE_TIMEOUT_EN to abort ISSUE after TIMEOUT_CYCLES cycles.
//
// state    | meaning
// IDLE     | no request; LSU grant follows data_req combinationally
// WAIT_TAG | load granted, waiting for its tag phase (or a kill)
// ISSUE    | held request presented to the controller until it completes
module ispm_lsu_bridge
   import ispm_lsu_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  dcache_req_i_t lsu_req_i,
   output dcache_req_o_t lsu_req_o,
   output dcache_req_i_t spm_req_o,
   input  dcache_req_o_t spm_req_i,
   output logic          busy_o,
   output logic          timeout_o
);

   ispm_bridge_state_t state_q, state_d;
   logic [INDEX_W-1:0] index_q, index_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [BE_W-1:0]    be_q, be_d;
   logic [1:0]         size_q, size_d;
   logic               we_q, we_d;
   logic               killed_q, killed_d;

   logic complete;
   logic drop;
   logic expire;
   logic abort;

   assign complete = is_completion(we_q, spm_req_i);
   assign drop     = killed_q | lsu_req_i.kill_req;

`ifdef ISPM_LSU_BRIDGE_TIMEOUT_EN
   logic wd_clear;
   logic wd_en;

   assign wd_clear = (state_q != ISSUE);
   assign wd_en    = (state_q == ISSUE) && !complete;

   ispm_lsu_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (wd_clear),
      .en_i     (wd_en),
      .expire_o (expire)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign expire = 1'b0;
`endif

   assign busy_o    = (state_q != IDLE);
   assign timeout_o = abort;

   always_comb begin
      state_d  = state_q;
      index_d  = index_q;
      tag_d    = tag_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      size_d   = size_q;
      we_d     = we_q;
      killed_d = killed_q;
      abort    = 1'b0;

      lsu_req_o = '0;

      spm_req_o               = '0;
      spm_req_o.address_index = index_q;
      spm_req_o.address_tag   = tag_q;
      spm_req_o.data_wdata    = wdata_q;
      spm_req_o.data_be       = be_q;
      spm_req_o.data_size     = size_q;
      spm_req_o.data_we       = we_q;

      unique case (state_q)
         IDLE: begin
            lsu_req_o.data_gnt = lsu_req_i.data_req;
            if (lsu_req_i.data_req) begin
               index_d  = lsu_req_i.address_index;
               wdata_d  = lsu_req_i.data_wdata;
               be_d     = lsu_req_i.data_be;
               size_d   = lsu_req_i.data_size;
               we_d     = lsu_req_i.data_we;
               killed_d = 1'b0;
               // Stores carry their tag in the grant cycle; loads may too.
               if (lsu_req_i.data_we || lsu_req_i.tag_valid) begin
                  tag_d   = lsu_req_i.address_tag;
                  state_d = ISSUE;
               end else begin
                  state_d = WAIT_TAG;
               end
            end
         end

         WAIT_TAG: begin
            if (lsu_req_i.kill_req) begin
               state_d = IDLE;
            end else if (lsu_req_i.tag_valid) begin
               tag_d   = lsu_req_i.address_tag;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            // A kill here cannot retract the request; only the response is suppressed.
            spm_req_o.data_req  = !expire;
            spm_req_o.tag_valid = 1'b1;
            killed_d            = drop;
            if (complete) begin
               state_d = IDLE;
               if (!we_q && !drop) begin
                  lsu_req_o.data_rvalid = 1'b1;
                  lsu_req_o.data_rdata  = spm_req_i.data_rdata;
               end
            end else if (expire) begin
               state_d = IDLE;
               abort   = 1'b1;
               if (!we_q && !drop) begin
                  lsu_req_o.data_rvalid = 1'b1;
                  lsu_req_o.data_rdata  = ISPM_ERR_RDATA;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         index_q  <= '0;
         tag_q    <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         size_q   <= '0;
         we_q     <= 1'b0;
         killed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         index_q  <= index_d;
         tag_q    <= tag_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         size_q   <= size_d;
         we_q     <= we_d;
         killed_q <= killed_d;
      end
   end

endmodule

// File: tb/tb_ispm_lsu_bridge.sv
// Self-checking bench for ispm_lsu_bridge: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ispm_lsu_bridge;
   import ispm_lsu_bridge_pkg::*;

`ifdef ISPM_LSU_BRIDGE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int unsigned TO_CYC = 8;

   logic          clk_i  = 1'b0;
   logic          rst_ni = 1'b0;
   dcache_req_i_t lsu_in;
   dcache_req_o_t lsu_out;
   dcache_req_i_t spm_out;
   dcache_req_o_t spm_in;
   logic          busy;
   logic          tmo;

   always #5 clk_i = ~clk_i;

   ispm_lsu_bridge #(
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .lsu_req_i (lsu_in),
      .lsu_req_o (lsu_out),
      .spm_req_o (spm_out),
      .spm_req_i (spm_in),
      .busy_o    (busy),
      .timeout_o (tmo)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a request is "pending" from grant to completion, and is
   // "presented" to the controller once its tag is known.
   bit            m_pend;
   bit            m_tagk;
   bit            m_kill;
   int            m_cnt;
   dcache_req_i_t m_hold;

   dcache_req_o_t s_lsu;
   dcache_req_i_t s_spm;
   logic          s_busy;
   logic          s_to;

   task automatic model_clear();
      m_pend = 1'b0;
      m_tagk = 1'b0;
      m_kill = 1'b0;
      m_cnt  = 0;
      m_hold = '0;
   endtask

   task automatic cyc();
      dcache_req_o_t e_lsu;
      dcache_req_i_t e_spm;
      logic          e_to;
      bit            done;
      bit            drop;
      bit            abort;
      @(negedge clk_i);
      e_lsu = '0;
      e_spm = m_hold;
      e_to  = 1'b0;
      done  = m_hold.data_we ? spm_in.data_gnt : spm_in.data_rvalid;
      drop  = m_kill || lsu_in.kill_req;
      abort = TO_EN && m_pend && m_tagk && !done && (m_cnt == TO_CYC);
      if (!m_pend) begin
         e_lsu.data_gnt = lsu_in.data_req;
      end else if (m_tagk) begin
         e_spm.data_req  = !abort;
         e_spm.tag_valid = 1'b1;
         if (done && !m_hold.data_we && !drop) begin
            e_lsu.data_rvalid = 1'b1;
            e_lsu.data_rdata  = spm_in.data_rdata;
         end else if (abort) begin
            e_to = 1'b1;
            if (!m_hold.data_we && !drop) begin
               e_lsu.data_rvalid = 1'b1;
               e_lsu.data_rdata  = ISPM_ERR_RDATA;
            end
         end
      end
      s_lsu  = lsu_out;
      s_spm  = spm_out;
      s_busy = busy;
      s_to   = tmo;
      chk("lsu_req_o", 192'(lsu_out), 192'(e_lsu));
      chk("spm_req_o", 192'(spm_out), 192'(e_spm));
      chk("busy_o", 192'(busy), 192'(m_pend));
      chk("timeout_o", 192'(tmo), 192'(e_to));
      if (!m_pend) begin
         if (lsu_in.data_req) begin
            m_pend                 = 1'b1;
            m_kill                 = 1'b0;
            m_cnt                  = 0;
            m_hold.address_index   = lsu_in.address_index;
            m_hold.data_wdata      = lsu_in.data_wdata;
            m_hold.data_be         = lsu_in.data_be;
            m_hold.data_size       = lsu_in.data_size;
            m_hold.data_we         = lsu_in.data_we;
            m_tagk                 = lsu_in.data_we || lsu_in.tag_valid;
            if (m_tagk) m_hold.address_tag = lsu_in.address_tag;
         end
      end else if (!m_tagk) begin
         if (lsu_in.kill_req) begin
            m_pend = 1'b0;
         end else if (lsu_in.tag_valid) begin
            m_tagk             = 1'b1;
            m_cnt              = 0;
            m_hold.address_tag = lsu_in.address_tag;
         end
      end else begin
         if (done || abort) begin
            m_pend = 1'b0;
            m_tagk = 1'b0;
         end else begin
            m_cnt++;
            m_kill = drop;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input bit req, input bit we, input logic [INDEX_W-1:0] idx, input bit tv,
                        input logic [TAG_W-1:0] tag, input bit kill, input bit sg, input bit srv,
                        input logic [DATA_W-1:0] rd);
      lsu_in               = '0;
      lsu_in.data_req      = req;
      lsu_in.data_we       = we;
      lsu_in.address_index = idx;
      lsu_in.tag_valid     = tv;
      lsu_in.address_tag   = tag;
      lsu_in.kill_req      = kill;
      lsu_in.data_wdata    = 64'hDEAD_BEEF;
      lsu_in.data_be       = 8'h0F;
      lsu_in.data_size     = 2'd2;
      spm_in               = '0;
      spm_in.data_gnt      = sg;
      spm_in.data_rvalid   = srv;
      spm_in.data_rdata    = rd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   typedef struct {
      bit                 req, we, tv, kill, sg, srv;
      logic [INDEX_W-1:0] idx;
      logic [TAG_W-1:0]   tag;
      logic [DATA_W-1:0]  rd;
      bit                 e_gnt, e_rv, e_sreq, e_busy;
      logic [DATA_W-1:0]  e_rd;
      logic [INDEX_W-1:0] e_idx;
      logic [TAG_W-1:0]   e_tag;
   } vec_t;

   function automatic vec_t mk(bit req, bit we, int idx, bit tv, int tag, bit kill, bit sg, bit srv,
                               logic [DATA_W-1:0] rd, bit e_gnt, bit e_rv, logic [DATA_W-1:0] e_rd,
                               bit e_sreq, int e_idx, int e_tag, bit e_busy);
      vec_t v;
      v.req = req; v.we = we; v.idx = INDEX_W'(idx); v.tv = tv; v.tag = TAG_W'(tag);
      v.kill = kill; v.sg = sg; v.srv = srv; v.rd = rd;
      v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rd = e_rd; v.e_sreq = e_sreq;
      v.e_idx = INDEX_W'(e_idx); v.e_tag = TAG_W'(e_tag); v.e_busy = e_busy;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      dcache_req_i_t held;
      int            rv_cnt;
      int            n_issue;
      bit            seen;

      // store, load with late tag, back-to-back loads, kills, stale responses
      vecs.push_back(mk(1,1,'h040,0,1,0,0,0,0,        1,0,0,        0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        1,'h040,1,1));
      vecs.push_back(mk(0,0,0,0,0,0,1,0,0,             0,0,0,        1,'h040,1,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        0,0,0,0));
      vecs.push_back(mk(1,0,'h088,0,0,0,0,0,0,         1,0,0,        0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        0,0,0,1));
      vecs.push_back(mk(0,0,0,1,2,0,0,0,0,             0,0,0,        0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,1,'h1234,        0,1,'h1234,   1,'h088,2,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        0,0,0,0));
      vecs.push_back(mk(1,0,'h100,1,3,0,0,0,0,         1,0,0,        0,0,0,0));
      vecs.push_back(mk(1,0,'h108,0,0,0,0,1,'hAAAA,    0,1,'hAAAA,   1,'h100,3,1));
      vecs.push_back(mk(1,0,'h108,1,4,0,0,0,0,         1,0,0,        0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,1,'hBBBB,        0,1,'hBBBB,   1,'h108,4,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        0,0,0,0));
      vecs.push_back(mk(1,0,'h0C0,0,0,0,0,0,0,         1,0,0,        0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,0,0,             0,0,0,        0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,1,'h5555,        0,0,0,        0,0,0,0));
      vecs.push_back(mk(1,0,'h0C8,1,5,0,0,0,0,         1,0,0,        0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,0,0,             0,0,0,        1,'h0C8,5,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        1,'h0C8,5,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,1,'h7777,        0,0,0,        1,'h0C8,5,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        0,0,0,0));
      vecs.push_back(mk(1,0,'h0D0,1,6,0,0,0,0,         1,0,0,        0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,0,1,'h9999,        0,0,0,        1,'h0D0,6,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        0,0,0,0));
      vecs.push_back(mk(1,1,'h0E0,0,7,0,0,0,0,         1,0,0,        0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,1,'h1111,        0,0,0,        1,'h0E0,7,1));
      vecs.push_back(mk(0,0,0,0,0,0,1,0,0,             0,0,0,        1,'h0E0,7,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,             0,0,0,        0,0,0,0));

      idle();
      model_clear();
      rst_ni = 1'b0;
      #3;
      chk("reset lsu_req_o", 192'(lsu_out), 192'(0));
      chk("reset spm_req_o", 192'(spm_out), 192'(0));
      chk("reset busy_o", 192'(busy), 192'(0));
      chk("reset timeout_o", 192'(tmo), 192'(0));
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].req, vecs[i].we, vecs[i].idx, vecs[i].tv, vecs[i].tag, vecs[i].kill,
               vecs[i].sg, vecs[i].srv, vecs[i].rd);
         cyc();
         chk($sformatf("tbl[%0d] gnt", i), 192'(s_lsu.data_gnt), 192'(vecs[i].e_gnt));
         chk($sformatf("tbl[%0d] rvalid", i), 192'(s_lsu.data_rvalid), 192'(vecs[i].e_rv));
         chk($sformatf("tbl[%0d] rdata", i), 192'(s_lsu.data_rdata), 192'(vecs[i].e_rd));
         chk($sformatf("tbl[%0d] spm data_req", i), 192'(s_spm.data_req), 192'(vecs[i].e_sreq));
         chk($sformatf("tbl[%0d] busy", i), 192'(s_busy), 192'(vecs[i].e_busy));
         if (vecs[i].e_sreq) begin
            chk($sformatf("tbl[%0d] spm index", i), 192'(s_spm.address_index), 192'(vecs[i].e_idx));
            chk($sformatf("tbl[%0d] spm tag", i), 192'(s_spm.address_tag), 192'(vecs[i].e_tag));
         end
      end

      // load stalled by instruction fetch for 5 cycles: request must not move
      drive(1'b1, 1'b0, 12'h200, 1'b1, 44'h9, 1'b0, 1'b0, 1'b0, '0);
      cyc();
      rv_cnt = 0;
      held   = '0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, (i == 2), 1'b0, '0);
         cyc();
         if (i == 0) held = s_spm;
         chk("stall spm_req held", 192'(s_spm), 192'(held));
         chk("stall data_req", 192'(s_spm.data_req), 192'(1));
         rv_cnt += int'(s_lsu.data_rvalid);
      end
      chk("stall index", 192'(held.address_index), 192'(12'h200));
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 64'hCAFE);
      cyc();
      rv_cnt += int'(s_lsu.data_rvalid);
      chk("stall rdata", 192'(s_lsu.data_rdata), 192'(64'hCAFE));
      idle();
      cyc();
      rv_cnt += int'(s_lsu.data_rvalid);
      chk("stall single rvalid", 192'(rv_cnt), 192'(1));

      // controller never answers
      drive(1'b1, 1'b0, 12'h300, 1'b1, 44'hA, 1'b0, 1'b0, 1'b0, '0);
      cyc();
      n_issue = 0;
      seen    = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         idle();
         cyc();
         if (s_to) seen = 1'b1;
         else n_issue++;
      end
`ifdef ISPM_LSU_BRIDGE_TIMEOUT_EN
      chk("timeout seen", 192'(seen), 192'(1));
      chk("timeout issue cycles", 192'(n_issue), 192'(TO_CYC));
      chk("timeout rvalid", 192'(s_lsu.data_rvalid), 192'(1));
      chk("timeout rdata", 192'(s_lsu.data_rdata), 192'(64'hCA11AB1E_BADCAB1E));
      chk("timeout data_req drop", 192'(s_spm.data_req), 192'(0));
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h4444);
      cyc();
      chk("late rvalid ignored", 192'(s_lsu.data_rvalid), 192'(0));
      chk("late rvalid idle", 192'(s_busy), 192'(0));
`else
      chk("no timeout", 192'(seen), 192'(0));
      chk("still waiting", 192'(s_busy), 192'(1));
      chk("still requesting", 192'(s_spm.data_req), 192'(1));
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 64'h4444);
      cyc();
      chk("late completion rvalid", 192'(s_lsu.data_rvalid), 192'(1));
      chk("late completion rdata", 192'(s_lsu.data_rdata), 192'(64'h4444));
`endif

      // reset in the middle of ISSUE
      drive(1'b1, 1'b0, 12'h3C0, 1'b1, 44'hB, 1'b0, 1'b0, 1'b0, '0);
      cyc();
      idle();
      #2;
      rst_ni = 1'b0;
      #1;
      chk("midreset lsu_req_o", 192'(lsu_out), 192'(0));
      chk("midreset spm_req_o", 192'(spm_out), 192'(0));
      chk("midreset busy_o", 192'(busy), 192'(0));
      chk("midreset timeout_o", 192'(tmo), 192'(0));
      model_clear();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      cyc();

      // randomized traffic against the reference model
      for (int i = 0; i < 1500; i++) begin
         lsu_in               = '0;
         lsu_in.data_req      = ($urandom_range(0, 1) == 1);
         lsu_in.data_we       = ($urandom_range(0, 1) == 1);
         lsu_in.address_index = INDEX_W'($urandom());
         lsu_in.address_tag   = TAG_W'({$urandom(), $urandom()});
         lsu_in.data_wdata    = {$urandom(), $urandom()};
         lsu_in.data_be       = BE_W'($urandom());
         lsu_in.data_size     = 2'($urandom());
         lsu_in.tag_valid     = ($urandom_range(0, 9) < 4);
         lsu_in.kill_req      = ($urandom_range(0, 99) < 8);
         spm_in               = '0;
         spm_in.data_gnt      = ($urandom_range(0, 99) < 35);
         spm_in.data_rvalid   = ($urandom_range(0, 99) < 35);
         spm_in.data_rdata    = {$urandom(), $urandom()};
         cyc();
      end

      idle();
      for (int i = 0; i < 3; i++) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
